// File: rtl/y_mc_ctrl.sv
// rtl/y_mc_ctrl.sv - multi-cycle RV32-subset control unit
// Sequences fetch/decode/exec/mem/wb with bus timeouts, traps, interrupt vectoring and perf counters.
module y_mc_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             INT,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             Link,
  output logic [2:0]       op,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_VECTOR = 3'd5
  } state_t;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_ADDI   = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur, nxt;
  logic       int_pend;
  logic       illegal_q, bus_err_q;
  logic [7:0] wait_cnt, wait_nxt;
  logic       set_illegal, set_bus_err, complete;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_ins;

  assign opc        = ins[6:0];
  assign f3         = ins[14:12];
  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Mem2Reg     = 1'b0;
    Link        = 1'b0;
    op          = ALU_ADD;
    nxt         = cur;
    wait_nxt    = 8'd0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    complete    = 1'b0;

    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_bus_err = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end

      S_DECODE: begin
        case (opc)
          OPC_R, OPC_ADDI, OPC_LOAD, OPC_STORE, OPC_BRANCH: nxt = S_EXEC;
          OPC_JAL: nxt = S_WB;
          default: set_illegal = 1'b1;
        endcase
      end

      S_EXEC: begin
        case (opc)
          OPC_R: begin
            nxt = S_WB;
            case (f3)
              3'd0:    op = ins[30] ? ALU_SUB : ALU_ADD;
              3'd7:    op = ALU_AND;
              3'd6:    op = ALU_OR;
              3'd2:    op = ALU_SLT;
              default: set_illegal = 1'b1;
            endcase
          end
          OPC_ADDI: begin
            ALUSrc = 1'b1;
            nxt    = S_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            ALUSrc = 1'b1;
            nxt    = S_MEM;
          end
          OPC_BRANCH: begin
            op       = ALU_SUB;
            pc_we    = 1'b1;
            pc_sel   = zero ? 2'd1 : 2'd0;
            complete = 1'b1;
          end
          default: set_illegal = 1'b1;
        endcase
      end

      S_MEM: begin
        case (opc)
          OPC_LOAD: begin
            MemRead = 1'b1;
            if (dmem_ready) nxt = S_WB;
          end
          OPC_STORE: begin
            MemWrite = 1'b1;
            if (dmem_ready) begin
              pc_we    = 1'b1;
              complete = 1'b1;
            end
          end
          default: set_illegal = 1'b1;
        endcase
        // Only a live access that is still waiting can time out.
        if (!dmem_ready && !set_illegal) begin
          if (wait_cnt == WAIT_LAST) set_bus_err = 1'b1;
          else                       wait_nxt    = wait_cnt + 8'd1;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        pc_we    = 1'b1;
        complete = 1'b1;
        Mem2Reg  = (opc == OPC_LOAD);
        if (opc == OPC_JAL) begin
          Link   = 1'b1;
          pc_sel = 2'd2;
        end
      end

      S_VECTOR: begin
        pc_we  = 1'b1;
        pc_sel = 2'd3;
        nxt    = S_FETCH;
      end

      default: nxt = S_VECTOR;
    endcase

    if (complete)                   nxt = (int_pend || INT) ? S_VECTOR : S_FETCH;
    if (set_illegal || set_bus_err) nxt = S_VECTOR;

    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'd0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Mem2Reg  = 1'b0;
      Link     = 1'b0;
      op       = ALU_ADD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= S_VECTOR;
      int_pend  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_cnt  <= 8'd0;
      cycles    <= '0;
      retired   <= '0;
    end else begin
      cur       <= nxt;
      wait_cnt  <= wait_nxt;
      cycles    <= cycles + CNT_W'(1);
      if (complete) retired <= retired + CNT_W'(1);
      // VECTOR is always a single cycle, so leaving it is simply being in it.
      int_pend  <= INT || (int_pend && (cur != S_VECTOR));
      illegal_q <= set_illegal;
      bus_err_q <= set_bus_err;
    end
  end

  assign state   = cur;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// tb/tb_y_mc_ctrl.sv - self-checking bench for y_mc_ctrl
// Expected per-cycle behaviour comes from a row list built from the instruction-level rules.
module tb_y_mc_ctrl;

  localparam int CNT_W = 32;
  localparam int TO    = 15;

  logic             clk, rst, INT, zero, imem_ready, dmem_ready;
  logic [31:0]      ins;
  logic             imem_req, ir_we, pc_we, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, Link;
  logic             illegal, bus_err;
  logic [1:0]       pc_sel;
  logic [2:0]       op, state;
  logic [CNT_W-1:0] cycles, retired;

  y_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .INT(INT), .ins(ins), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem2Reg(Mem2Reg), .Link(Link), .op(op), .state(state),
    .illegal(illegal), .bus_err(bus_err), .cycles(cycles), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] st;
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       rw, alusrc, mr, mw, m2r, link;
    logic [2:0] op;
    logic       ill, berr;
    logic       imr, dmr, intr, ret;
  } row_t;

  row_t rows[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cycles = 0;
  int   exp_ret = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic row_t blank(input logic [2:0] st);
    row_t r;
    r = '{st: st, imem_req: 1'b0, ir_we: 1'b0, pc_we: 1'b0, pc_sel: 2'd0, rw: 1'b0,
          alusrc: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, link: 1'b0, op: 3'b010,
          ill: 1'b0, berr: 1'b0, imr: 1'b0, dmr: 1'b0, intr: 1'b0, ret: 1'b0};
    return r;
  endfunction

  function automatic row_t vec(input logic ill, input logic berr);
    row_t r;
    r = blank(3'd5);
    r.pc_we = 1'b1; r.pc_sel = 2'd3; r.ill = ill; r.berr = berr;
    return r;
  endfunction

  function automatic logic [18:0] exp_vec(input row_t r);
    return {r.st, r.imem_req, r.ir_we, r.pc_we, r.pc_sel, r.rw, r.alusrc,
            r.mr, r.mw, r.m2r, r.link, r.op, r.ill, r.berr};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {state, imem_req, ir_we, pc_we, pc_sel, RegWrite, ALUSrc,
            MemRead, MemWrite, Mem2Reg, Link, op, illegal, bus_err};
  endfunction

  // Expand one instruction into its expected cycles, starting in FETCH.
  task automatic build(input logic [31:0] i, input logic z, input int idly, input int ddly,
                       input int int_idx);
    row_t r;
    int   n0 = rows.size();
    int   n;
    logic done = 1'b0, itrap = 1'b0, btrap = 1'b0;
    logic [6:0] opc = i[6:0];
    logic [2:0] f3 = i[14:12];
    for (int k = 0; k < TO; k++) begin
      r = blank(3'd0); r.imem_req = 1'b1;
      if (k == idly) begin r.ir_we = 1'b1; r.imr = 1'b1; end
      rows.push_back(r);
      if (k == idly) break;
    end
    if (idly >= TO) btrap = 1'b1;
    else begin
      rows.push_back(blank(3'd1));
      if (opc == 7'h6F) begin
        r = blank(3'd4); r.rw = 1'b1; r.pc_we = 1'b1; r.ret = 1'b1;
        r.link = 1'b1; r.pc_sel = 2'd2;
        rows.push_back(r); done = 1'b1;
      end else if (opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63}) begin
        r = blank(3'd2);
        if (opc == 7'h33) begin
          case (f3)
            3'd0: r.op = i[30] ? 3'b110 : 3'b010;
            3'd7: r.op = 3'b000;
            3'd6: r.op = 3'b001;
            3'd2: r.op = 3'b111;
            default: itrap = 1'b1;
          endcase
        end else if (opc == 7'h63) begin
          r.op = 3'b110; r.pc_we = 1'b1; r.pc_sel = {1'b0, z}; r.ret = 1'b1; done = 1'b1;
        end else r.alusrc = 1'b1;
        rows.push_back(r);
        if (!itrap && !done) begin
          if (opc == 7'h03 || opc == 7'h23) begin
            for (int k = 0; k < TO; k++) begin
              r = blank(3'd3);
              if (opc == 7'h03) r.mr = 1'b1; else r.mw = 1'b1;
              if (k == ddly) begin
                r.dmr = 1'b1;
                if (opc == 7'h23) begin r.pc_we = 1'b1; r.ret = 1'b1; done = 1'b1; end
              end
              rows.push_back(r);
              if (k == ddly) break;
            end
            if (ddly >= TO) btrap = 1'b1;
          end
          if (!btrap && !done) begin
            r = blank(3'd4); r.rw = 1'b1; r.pc_we = 1'b1; r.ret = 1'b1;
            r.m2r = (opc == 7'h03);
            rows.push_back(r); done = 1'b1;
          end
        end
      end else itrap = 1'b1;
    end
    n = rows.size() - n0;
    if (int_idx >= 0) begin
      r = rows[n0 + (int_idx % n)]; r.intr = 1'b1; rows[n0 + (int_idx % n)] = r;
    end
    if (itrap)                       rows.push_back(vec(1'b1, 1'b0));
    else if (btrap)                  rows.push_back(vec(1'b0, 1'b1));
    else if (done && int_idx >= 0)   rows.push_back(vec(1'b0, 1'b0));
  endtask

  task automatic run_rows(input logic [31:0] i, input logic z, input int maxn);
    row_t r;
    int   n = 0;
    while (rows.size() > 0 && n < maxn) begin
      r = rows.pop_front();
      ins = i; zero = z; imem_ready = r.imr; dmem_ready = r.dmr; INT = r.intr;
      #1;
      chk($sformatf("row ins=%08h n=%0d", i, n), {45'd0, dut_vec()}, {45'd0, exp_vec(r)});
      if (r.ret) exp_ret++;
      @(posedge clk); #1;
      exp_cycles++;
      n++;
    end
    rows.delete();
    INT = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, " cycles"}, 64'(cycles), 64'(exp_cycles));
    chk({tag, " retired"}, 64'(retired), 64'(exp_ret));
  endtask

  task automatic instr(input logic [31:0] i, input logic z, input int idly, input int ddly,
                       input int int_idx);
    build(i, z, idly, ddly, int_idx);
    run_rows(i, z, 1000);
    check_counters($sformatf("ins=%08h", i));
  endtask

  logic [31:0] pool [12];

  initial begin
    int sel, idly, ddly, iidx;
    pool = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3, 32'h0000A183,
             32'h00108193, 32'h0030A023, 32'h00208063, 32'h008000EF, 32'h002091B3, 32'h0000007F};
    rst = 1'b1; INT = 1'b0; ins = 32'h0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #2;
    chk("reset state", 64'(state), 64'd5);
    chk("reset cycles", 64'(cycles), 64'd0);
    chk("reset retired", 64'(retired), 64'd0);
    chk("reset enables", {59'd0, pc_we, RegWrite, MemWrite, imem_req, illegal | bus_err}, 64'd0);
    #10 rst = 1'b0;

    rows.push_back(vec(1'b0, 1'b0));
    run_rows(32'h0, 1'b0, 1000);
    instr(32'h002081B3, 1'b0, 0, 0, -1);
    chk("add cycles", 64'(cycles), 64'd5);
    chk("add retired", 64'(retired), 64'd1);

    instr(32'h0000A183, 1'b0, 0, 3, -1);
    instr(32'h00208063, 1'b1, 1, 0, -1);
    instr(32'h00208063, 1'b0, 0, 0, -1);
    instr(32'h00108193, 1'b0, 0, 0, 2);
    instr(32'h0000007F, 1'b0, 0, 0, -1);
    instr(32'h0030A023, 1'b0, 0, 100, -1);
    instr(32'h002091B3, 1'b0, 0, 0, -1);
    instr(32'h008000EF, 1'b0, 2, 0, -1);
    instr(32'h002081B3, 1'b0, 100, 0, -1);

    for (int t = 0; t < 40; t++) begin
      sel  = $urandom_range(0, 11);
      idly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      ddly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      iidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      instr(pool[sel], 1'($urandom_range(0, 1)), idly, ddly, iidx);
    end

    // Reset in the middle of a stalled load.
    build(32'h0000A183, 1'b0, 0, 100, -1);
    run_rows(32'h0000A183, 1'b0, 5);
    ins = 32'h0000A183; dmem_ready = 1'b0;
    #1;
    chk("pre-reset MemRead", 64'(MemRead), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid reset state", 64'(state), 64'd5);
    chk("mid reset cycles", 64'(cycles), 64'd0);
    chk("mid reset retired", 64'(retired), 64'd0);
    chk("mid reset enables", {56'd0, MemRead, RegWrite, pc_we, pc_sel, imem_req, ir_we, Mem2Reg}, 64'd0);
    @(posedge clk); #1;
    chk("held reset cycles", 64'(cycles), 64'd0);
    #2 rst = 1'b0;
    exp_cycles = 0; exp_ret = 0;
    rows.push_back(vec(1'b0, 1'b0));
    run_rows(32'h0, 1'b0, 1000);
    instr(32'h00108193, 1'b0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog expired observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
